adc_ctrl: RTL and testbench
===========================

ADC_CTRL -- requirements
Module: adc_ctrl

Interface
REQ-001 SHALL have parameter START_CYCLES, default 2, the number of cycles `start` is held high (legal range 1..255).
REQ-002 SHALL have parameter OE_CYCLES, default 2, the number of cycles `OE` is held high (legal range 2..255).
REQ-003 SHALL have parameter TIMEOUT, default 1024, the maximum number of cycles spent waiting on any single EOC edge (legal range 4..65535).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port sample_req, input, 1 bit: conversion request, sampled only in IDLE.
REQ-007 SHALL have port start, output, 1 bit: converter start strobe.
REQ-008 SHALL have port EOC, input, 1 bit: converter end-of-conversion, synchronous to clk; no synchronizer.
REQ-009 SHALL have port OE, output, 1 bit: converter output enable.
REQ-010 SHALL have port adc_data, input, 12 bits: converter result bus.
REQ-011 SHALL have port sample_data, output, 12 bits: last captured result.
REQ-012 SHALL have port sample_valid, output, 1 bit: one-cycle pulse when sample_data updates.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port timeout, output, 1 bit: one-cycle pulse on an aborted conversion.

Function
REQ-015 SHALL implement states IDLE, START, WAIT_LOW, WAIT_HIGH, OE_HI, OE_LO and CAPTURE; all outputs SHALL be registered.
REQ-016 IDLE: sample_req=1 at a clock edge SHALL move to START; `start` goes high on that same edge.
REQ-017 START: `start` SHALL stay high for exactly START_CYCLES cycles, then drop low as the FSM enters WAIT_LOW.
REQ-018 WAIT_LOW: EOC=0 SHALL move the FSM to WAIT_HIGH (conversion acknowledged).
REQ-019 WAIT_HIGH: EOC=1 SHALL move the FSM to OE_HI, and OE goes high on that same edge.
REQ-020 OE_HI: OE SHALL stay high for exactly OE_CYCLES cycles, then drop low as the FSM enters OE_LO.
REQ-021 OE_LO: after one cycle with OE low, the FSM SHALL enter CAPTURE; this gives the converter time to update adc_data on an OE-high edge.
REQ-022 CAPTURE: the block SHALL register adc_data into sample_data, pulse sample_valid for 1 cycle, and return to IDLE.
REQ-023 From sample_req to sample_valid the latency SHALL be START_CYCLES + (cycles in WAIT_LOW) + (cycles in WAIT_HIGH) + OE_CYCLES + 2.
REQ-024 Timer: a 16-bit counter SHALL clear on entry to WAIT_LOW and on entry to WAIT_HIGH, and increment each cycle while in either state.
REQ-025 When the counter reaches TIMEOUT-1 without the awaited EOC level, the block SHALL pulse timeout for 1 cycle, go to IDLE with start=0 and OE=0, and leave sample_data unchanged.
REQ-026 If the awaited EOC level and the timeout limit occur in the same cycle, the EOC transition SHALL win and timeout SHALL NOT pulse.
REQ-027 sample_req while busy=1 SHALL be ignored; nothing is queued.
REQ-028 sample_req held high SHALL yield back-to-back conversions, with one IDLE cycle between CAPTURE and the next START.
REQ-029 start and OE SHALL never be high in the same cycle.
REQ-030 sample_data SHALL hold its value between captures.

Reset
REQ-031 rstn=0 SHALL immediately force state to IDLE and clear start, OE, sample_valid, timeout, busy and the timer, with sample_data set to 12'h000.
REQ-032 A reset in the middle of a conversion SHALL drop start and OE asynchronously, with no sample_valid pulse or timeout pulse on exit.
REQ-033 After rstn deasserts, the first conversion SHALL start only on a new sample_req seen in IDLE.

Structure
REQ-034 Shared package adc_pkg SHALL hold ADC_DATA_W=12, the 3-bit state encoding for adc_ctrl, and the default TIMEOUT constant.
REQ-035 The timer SHALL be one sub-module, adc_ctrl_timer, with inputs clr and en, a parameterized limit, and output expired.
REQ-036 The FSM, the start/OE length counters and the capture register SHALL live in adc_ctrl.

Verification
REQ-037 Nominal: with defaults, connected to the team's converter model (convert_time=10) and anadata giving 12'hA5C, a 1-cycle sample_req SHALL produce start high for 2 cycles, OE high for 2 cycles, a single sample_valid, and sample_data=12'hA5C.
REQ-038 Back-to-back: sample_req held high for 3 conversions with the data changing 12'h001→12'h002→12'h003 SHALL give 3 sample_valid pulses carrying those values in order, with no overlap of start and OE.
REQ-039 Timeout: with EOC tied to 1 and TIMEOUT=16, a request SHALL produce a timeout pulse exactly 16 cycles after WAIT_LOW entry, followed by IDLE with sample_data unchanged.
REQ-040 Simultaneous: with EOC driven to 0 in the same cycle the timer reaches TIMEOUT-1, the FSM SHALL advance to WAIT_HIGH and timeout SHALL stay 0.
REQ-041 Reset mid-op: rstn pulled low during OE_HI SHALL make OE=0 within the same cycle; after release, busy=0 and sample_data=12'h000.
REQ-042 Busy ignore: a sample_req pulse during WAIT_HIGH SHALL produce exactly one sample_valid in total.

Source files
------------

// File: rtl/adc_pkg.sv
// adc_pkg: constants and the state encoding shared by the ADC controller files.
//   ADC_DATA_W      - converter result width
//   TIMEOUT_DEFAULT - default EOC wait limit, in cycles
//   TIMER_W         - width of the EOC wait timer
//   adc_state_t     - 3-bit controller state encoding
package adc_pkg;

    localparam int ADC_DATA_W      = 12;
    localparam int TIMEOUT_DEFAULT = 1024;
    localparam int TIMER_W         = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_OE_HI     = 3'd4,
        S_OE_LO     = 3'd5,
        S_CAPTURE   = 3'd6
    } adc_state_t;

endpackage

// File: rtl/adc_ctrl_timer.sv
// adc_ctrl_timer: 16-bit wait timer that bounds each EOC wait.
//   clk, rstn - clock, asynchronous active-low reset
//   clr       - restart the count at zero (has priority over en)
//   en        - count up by one this cycle
//   expired   - count has reached LIMIT-1
module adc_ctrl_timer
    import adc_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEFAULT
)(
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expired = (count == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/adc_ctrl.sv
// adc_ctrl: sequencer for a start/EOC/OE handshake ADC.
//   clk, rstn    - clock, asynchronous active-low reset
//   sample_req   - conversion request, only honoured in IDLE
//   start        - converter start strobe (START_CYCLES long)
//   EOC          - converter end-of-conversion (already synchronous)
//   OE           - converter output enable (OE_CYCLES long)
//   adc_data     - converter result bus
//   sample_data  - last captured result
//   sample_valid - one-cycle pulse when sample_data updates
//   busy         - controller not in IDLE
//   timeout      - one-cycle pulse when a conversion is abandoned
module adc_ctrl
    import adc_pkg::*;
#(
    parameter int START_CYCLES = 2,
    parameter int OE_CYCLES    = 2,
    parameter int TIMEOUT      = TIMEOUT_DEFAULT
)(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sample_req,
    output logic                  start,
    input  logic                  EOC,
    output logic                  OE,
    input  logic [ADC_DATA_W-1:0] adc_data,
    output logic [ADC_DATA_W-1:0] sample_data,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  timeout
);

    adc_state_t state, next_state;
    logic [7:0] len_cnt;
    logic       entering;
    logic       tmr_clr, tmr_en, tmr_expired;
    logic       start_d, oe_d, busy_d, valid_d, timeout_d;

    assign entering = (next_state != state);
    assign tmr_en   = (state == S_WAIT_LOW) || (state == S_WAIT_HIGH);
    assign tmr_clr  = entering && ((next_state == S_WAIT_LOW) || (next_state == S_WAIT_HIGH));

    adc_ctrl_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // State, length counter and registered outputs. Outputs are decoded
    // from next_state so each strobe changes on the same edge as the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            len_cnt      <= '0;
            start        <= 1'b0;
            OE           <= 1'b0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            timeout      <= 1'b0;
            sample_data  <= '0;
        end else begin
            state        <= next_state;
            if (entering) begin
                len_cnt <= '0;
            end else if ((state == S_START) || (state == S_OE_HI)) begin
                len_cnt <= len_cnt + 8'd1;
            end
            start        <= start_d;
            OE           <= oe_d;
            busy         <= busy_d;
            sample_valid <= valid_d;
            timeout      <= timeout_d;
            if (state == S_CAPTURE) begin
                sample_data <= adc_data;
            end
        end
    end

    // The awaited EOC level is tested before the timer so that it wins
    // when both happen in the same cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:      if (sample_req) next_state = S_START;
            S_START:     if (len_cnt == 8'(START_CYCLES - 1)) next_state = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (!EOC)             next_state = S_WAIT_HIGH;
                else if (tmr_expired) next_state = S_IDLE;
            end
            S_WAIT_HIGH: begin
                if (EOC)              next_state = S_OE_HI;
                else if (tmr_expired) next_state = S_IDLE;
            end
            S_OE_HI:     if (len_cnt == 8'(OE_CYCLES - 1)) next_state = S_OE_LO;
            S_OE_LO:     next_state = S_CAPTURE;
            S_CAPTURE:   next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    always_comb begin
        start_d   = (next_state == S_START);
        oe_d      = (next_state == S_OE_HI);
        busy_d    = (next_state != S_IDLE);
        valid_d   = (state == S_CAPTURE);
        timeout_d = tmr_en && (next_state == S_IDLE);
    end

endmodule

// File: tb/tb_adc_ctrl.sv
// tb_adc_ctrl: self-checking bench for adc_ctrl. Each conversion is described
// by how many cycles EOC keeps the FSM in WAIT_LOW / WAIT_HIGH (0 = never),
// and the expected waveform timing is computed from those counts.
module tb_adc_ctrl;

    localparam int S_C = 2;
    localparam int O_C = 2;
    localparam int T_C = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sample_req;
    logic        start;
    logic        EOC;
    logic        OE;
    logic [11:0] adc_data;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        busy;
    logic        timeout;

    int          checks   = 0;
    int          failures = 0;
    logic [11:0] exp_data = '0;

    always #5 clk = ~clk;

    adc_ctrl #(
        .START_CYCLES (S_C),
        .OE_CYCLES    (O_C),
        .TIMEOUT      (T_C)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .sample_req   (sample_req),
        .start        (start),
        .EOC          (EOC),
        .OE           (OE),
        .adc_data     (adc_data),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .busy         (busy),
        .timeout      (timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // EOC level for cycle c after the request edge: high until the FSM has
    // spent l_cyc cycles in WAIT_LOW, low for h_cyc cycles of WAIT_HIGH.
    function automatic logic eoc_model(input int c, input int l_cyc, input int h_cyc);
        if (l_cyc == 0 || c < S_C + l_cyc - 1) return 1'b1;
        if (h_cyc == 0 || c < S_C + l_cyc + h_cyc - 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_conv(input string tag, input int l_cyc, input int h_cyc,
                            input logic [11:0] data, input bit hold, input int req_pulse);
        int exp_oe, exp_valid, exp_tmo, end_cyc;
        int start_n, oe_n, first_oe, valid_cyc, tmo_cyc, overlap, busy_err;
        exp_oe    = (l_cyc > 0 && h_cyc > 0) ? S_C + l_cyc + h_cyc : -1;
        exp_valid = (exp_oe >= 0) ? exp_oe + O_C + 2 : -1;
        exp_tmo   = (l_cyc == 0) ? S_C + T_C : ((exp_oe < 0) ? S_C + l_cyc + T_C : -1);
        end_cyc   = (exp_valid >= 0) ? exp_valid : exp_tmo;
        start_n = 0; oe_n = 0; first_oe = -1; valid_cyc = -1; tmo_cyc = -1;
        overlap = 0; busy_err = 0;
        adc_data   = ~data;
        sample_req = 1'b1;
        step();
        for (int c = 0; c < 200; c++) begin
            if (start === 1'b1) start_n++;
            if (OE === 1'b1) begin
                oe_n++;
                if (first_oe < 0) begin
                    first_oe = c;
                    adc_data = data;
                end
            end
            if (start === 1'b1 && OE === 1'b1) overlap++;
            if (busy !== (c < end_cyc)) busy_err++;
            if (sample_valid === 1'b1) valid_cyc = c;
            if (timeout === 1'b1) tmo_cyc = c;
            if (valid_cyc >= 0 || tmo_cyc >= 0) break;
            sample_req = hold || (c == req_pulse);
            EOC        = eoc_model(c, l_cyc, h_cyc);
            step();
        end
        EOC        = 1'b1;
        sample_req = hold;
        check($sformatf("%s.start_len", tag), start_n, S_C);
        check($sformatf("%s.oe_len", tag), oe_n, (exp_oe >= 0) ? O_C : 0);
        check($sformatf("%s.oe_cycle", tag), first_oe, exp_oe);
        check($sformatf("%s.valid_cycle", tag), valid_cyc, exp_valid);
        check($sformatf("%s.timeout_cycle", tag), tmo_cyc, exp_tmo);
        check($sformatf("%s.overlap", tag), overlap, 0);
        check($sformatf("%s.busy", tag), busy_err, 0);
        if (exp_valid >= 0) exp_data = data;
        check($sformatf("%s.sample_data", tag), 32'(sample_data), 32'(exp_data));
        if (!hold) begin
            step();
            check($sformatf("%s.pulse_end", tag), 32'({sample_valid, timeout, busy}), 32'(0));
        end
    endtask

    initial begin
        int l, h, r, seen, cnt_start, cnt_valid, cnt_busy;
        rstn       = 1'b0;
        sample_req = 1'b0;
        EOC        = 1'b1;
        adc_data   = '0;
        repeat (3) step();
        check("rst.start", 32'(start), 32'(0));
        check("rst.oe", 32'(OE), 32'(0));
        check("rst.valid", 32'(sample_valid), 32'(0));
        check("rst.timeout", 32'(timeout), 32'(0));
        check("rst.busy", 32'(busy), 32'(0));
        check("rst.sample_data", 32'(sample_data), 32'(0));
        @(posedge clk);
        #3 rstn = 1'b1;
        repeat (3) step();
        check("idle.busy", 32'(busy), 32'(0));

        run_conv("nominal", 2, 10, 12'hA5C, 1'b0, -1);

        run_conv("b2b1", 1, 3, 12'h001, 1'b1, -1);
        run_conv("b2b2", 2, 4, 12'h002, 1'b1, -1);
        run_conv("b2b3", 3, 2, 12'h003, 1'b0, -1);

        run_conv("tmo_low", 0, 0, 12'h777, 1'b0, -1);
        run_conv("tmo_high", 5, 0, 12'h666, 1'b0, -1);

        run_conv("edge_low", T_C, 3, 12'h0F0, 1'b0, -1);
        run_conv("edge_high", 1, T_C, 12'hF0F, 1'b0, -1);
        run_conv("edge_both", T_C, T_C, 12'h5A5, 1'b0, -1);

        run_conv("ignore", 2, 6, 12'h321, 1'b0, S_C + 4);
        cnt_start = 0;
        cnt_valid = 0;
        repeat (30) begin
            if (start === 1'b1) cnt_start++;
            if (sample_valid === 1'b1) cnt_valid++;
            step();
        end
        check("ignore.no_start", cnt_start, 0);
        check("ignore.no_valid", cnt_valid, 0);

        for (int i = 0; i < 12; i++) begin
            r = int'($urandom_range(0, 9));
            l = (r == 0) ? 0 : int'($urandom_range(1, T_C));
            h = (r == 1) ? 0 : int'($urandom_range(1, T_C));
            run_conv($sformatf("rand%0d", i), l, h, 12'($urandom), 1'b0, -1);
        end

        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        seen = -1;
        for (int c = 0; c < 40; c++) begin
            if (OE === 1'b1) begin
                seen = c;
                break;
            end
            EOC = eoc_model(c, 2, 2);
            step();
        end
        check("rst_mid.reach_oe", seen, S_C + 4);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid.oe", 32'(OE), 32'(0));
        check("rst_mid.start", 32'(start), 32'(0));
        check("rst_mid.busy", 32'(busy), 32'(0));
        exp_data = '0;
        EOC      = 1'b1;
        step();
        @(posedge clk);
        #3 rstn = 1'b1;
        step();
        check("rst_mid.sample_data", 32'(sample_data), 32'(exp_data));
        check("rst_mid.pulses", 32'({sample_valid, timeout}), 32'(0));
        cnt_busy = 0;
        repeat (5) begin
            if (busy !== 1'b0) cnt_busy++;
            step();
        end
        check("rst_mid.stay_idle", cnt_busy, 0);
        run_conv("post_rst", 3, 5, 12'h3C7, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
